// File: rtl/shmem_burst_arbiter.sv
// -----------------------------------------------------------------------------
// shmem_burst_arbiter
//
// Shares one single-port memory between NB_PORTS requesters. A requester wins
// ownership through a rotating-priority search and then keeps the memory for up
// to MAX_BURST consecutive accesses. Accesses are issued combinationally in the
// cycle the owner's request is seen. Read data returns READ_LATENCY cycles
// later and is steered back to the issuing port through a small tag pipeline.
//
// Ports:
//   clk          rising-edge clock for all logic
//   srst_n       synchronous active-low reset
//   req          per-port access request, held until acked
//   wren         per-port write enable (1 = write, 0 = read)
//   addr         per-port address, port i at [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH]
//   wdata        per-port write data, same packing as addr
//   ack          one-hot, access of port i issued this cycle
//   rvalid       one-hot, read data for port i present on rdata this cycle
//   rdata        mem_dataout broadcast to all ports
//   mem_en       memory access strobe
//   mem_wren     memory write enable
//   mem_addr     memory address
//   mem_datain   memory write data
//   mem_dataout  memory read data
// -----------------------------------------------------------------------------
module shmem_burst_arbiter #(
  parameter int NB_PORTS      = 4,
  parameter int LOG2_NB_PORTS = 2,
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST     = 4,
  parameter int READ_LATENCY  = 1
) (
  input  logic                           clk,
  input  logic                           srst_n,
  input  logic [NB_PORTS-1:0]            req,
  input  logic [NB_PORTS-1:0]            wren,
  input  logic [NB_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NB_PORTS*DATA_WIDTH-1:0] wdata,
  output logic [NB_PORTS-1:0]            ack,
  output logic [NB_PORTS-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           mem_en,
  output logic                           mem_wren,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_datain,
  input  logic [DATA_WIDTH-1:0]          mem_dataout
);

  // A one-access burst still needs a one-bit counter so the compare is legal.
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                                      state;
  logic [LOG2_NB_PORTS-1:0]                    owner;
  logic [LOG2_NB_PORTS-1:0]                    last_owner;
  logic [CNT_W-1:0]                            burst_cnt;

  logic [LOG2_NB_PORTS-1:0]                    arb_base;
  logic [LOG2_NB_PORTS-1:0]                    arb_idx;
  logic [LOG2_NB_PORTS-1:0]                    cand;
  logic                                        arb_found;
  logic                                        issue;

  logic [READ_LATENCY-1:0]                     rd_vld;
  logic [READ_LATENCY-1:0][LOG2_NB_PORTS-1:0]  rd_port;

  // Rotating-priority search. The search starts one past the base port and
  // wraps; the base port itself is checked last, so it only wins when nobody
  // else is asking. In IDLE the base is the previous owner; at the end of a
  // burst the base is the current owner, which then becomes last_owner, so a
  // single expression serves both cases. Scanning from the far end downwards
  // lets the nearest requester overwrite the result last.
  always_comb begin
    arb_base  = (state == IDLE) ? last_owner : owner;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = NB_PORTS; k >= 1; k--) begin
      cand = arb_base + LOG2_NB_PORTS'(k);
      if (req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // An access goes out whenever the owner is still requesting during a burst.
  // Holding everything low while srst_n is low keeps the memory quiet even
  // before the first reset edge has cleaned up the state.
  assign issue = srst_n && (state == BURST) && req[owner];

  // Memory-side mux. All memory signals and the ack vector are forced to zero
  // when no access is issued, so the memory never sees stale owner data.
  always_comb begin
    ack        = '0;
    mem_en     = 1'b0;
    mem_wren   = 1'b0;
    mem_addr   = '0;
    mem_datain = '0;
    if (issue) begin
      ack[owner] = 1'b1;
      mem_en     = 1'b1;
      mem_wren   = wren[owner];
      mem_addr   = addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_datain = wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The oldest entry of the tag pipeline tells which port the memory output
  // belongs to this cycle; the data itself is simply broadcast.
  always_comb begin
    rvalid = '0;
    if (srst_n && rd_vld[READ_LATENCY-1]) begin
      rvalid[rd_port[READ_LATENCY-1]] = 1'b1;
    end
  end

  assign rdata = mem_dataout;

  // Ownership state machine. IDLE only picks a winner and never accesses the
  // memory. In BURST the owner keeps the memory until it either stops
  // requesting (one dead cycle, then back to IDLE) or uses its last burst
  // slot, at which point a new winner is chosen on the spot so that a busy
  // system never loses a cycle between bursts.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LOG2_NB_PORTS'(NB_PORTS - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            state     <= BURST;
            owner     <= arb_idx;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          if (!req[owner]) begin
            last_owner <= owner;
            state      <= IDLE;
          end else if (burst_cnt == CNT_LAST) begin
            last_owner <= owner;
            burst_cnt  <= '0;
            if (arb_found) begin
              owner <= arb_idx;
            end else begin
              state <= IDLE;
            end
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Read tag pipeline: one {valid, port} entry per cycle of memory latency.
  // Writes enter as invalid entries so they never produce rvalid. Reset wipes
  // every entry, which drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rd_vld  <= '0;
      rd_port <= '0;
    end else begin
      rd_vld[0]  <= issue & ~wren[owner];
      rd_port[0] <= owner;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_port[i] <= rd_port[i-1];
      end
    end
  end

endmodule

// File: doc/shmem_burst_arbiter.md
SHMEM_BURST_ARBITER -- requirements
Module: shmem_burst_arbiter

Interface
REQ-001 Parameter NB_PORTS, default 4, number of requesters; SHALL equal 2**LOG2_NB_PORTS.
REQ-002 Parameter LOG2_NB_PORTS, default 2, width of the port index.
REQ-003 Parameter ADDR_WIDTH, default 12, memory address width.
REQ-004 Parameter DATA_WIDTH, default 32, memory data width.
REQ-005 Parameter MAX_BURST, default 4, maximum consecutive accesses per grant; valid range 1..16.
REQ-006 Parameter READ_LATENCY, default 1, cycles from read issue to mem_dataout valid; valid range 1..4.
REQ-007 Ports SHALL be:
- clk  in  1  single clock, all logic rising-edge.
- srst_n  in  1  synchronous, active-low reset.
- req  in  NB_PORTS  per-port access request, held until acked.
- wren  in  NB_PORTS  per-port write enable (1 = write, 0 = read).
- addr  in  NB_PORTS*ADDR_WIDTH  per-port address, port i at bits [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH].
- wdata  in  NB_PORTS*DATA_WIDTH  per-port write data, same packing.
- ack  out  NB_PORTS  one-hot; access of port i issued this cycle.
- rvalid  out  NB_PORTS  one-hot; read data for port i on rdata this cycle.
- rdata  out  DATA_WIDTH  mem_dataout broadcast to all ports.
- mem_en  out  1  memory access strobe.
- mem_wren  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_datain  out  DATA_WIDTH  memory write data.
- mem_dataout  in  DATA_WIDTH  memory read data.

Function
REQ-008 State machine SHALL have two states: IDLE and BURST; registers: owner (LOG2_NB_PORTS), last_owner (LOG2_NB_PORTS), burst_cnt (0..MAX_BURST-1).
REQ-009 Rotating priority: search starts at (last_owner+1) mod NB_PORTS, wraps, picks the first port with req=1.
REQ-010 IDLE: if any req, next state BURST, owner = selected port, burst_cnt = 0; else stay IDLE; no access in IDLE.
REQ-011 BURST, req[owner]=1: access issued combinationally this cycle: mem_en=1, ack[owner]=1, mem_wren=wren[owner], mem_addr/mem_datain = owner's slices.
REQ-012 BURST, access issued with burst_cnt<MAX_BURST-1: burst_cnt increments, owner unchanged.
REQ-013 BURST, access issued with burst_cnt=MAX_BURST-1: last_owner=owner, rearbitrate per REQ-009 (current owner eligible, lowest priority); if a winner exists, next state BURST with new owner, burst_cnt=0, no idle cycle; else IDLE.
REQ-014 BURST, req[owner]=0: no access this cycle (one dead cycle), last_owner=owner, next state IDLE.
REQ-015 When mem_en=0, mem_wren, mem_addr, mem_datain SHALL be 0 and ack SHALL be 0.
REQ-016 Read return: for each issued access with mem_wren=0, rvalid[owner] SHALL pulse exactly READ_LATENCY cycles later, with rdata=mem_dataout; tracked by a READ_LATENCY-deep pipeline of {valid, port index}.
REQ-017 Writes SHALL never produce rvalid.
REQ-018 Back-to-back reads, including across owner change, SHALL each return in order, one per cycle.
REQ-019 req changes on non-owner ports SHALL not affect the current burst.
REQ-020 Exactly one of ack bits high at most; exactly one rvalid bit high at most.

Reset
REQ-021 When srst_n=0 at a rising edge: state=IDLE, owner=0, last_owner=NB_PORTS-1, burst_cnt=0, read pipeline cleared.
REQ-022 Consequently during and immediately after reset: mem_en=0, ack=0, rvalid=0, mem_wren/mem_addr/mem_datain=0; rdata follows mem_dataout.
REQ-023 Reset mid-burst or with reads in flight SHALL abort them; no rvalid for pre-reset reads; first post-reset grant favours port 0.

Verification
REQ-024 Defaults, reset release, req=4'b1111 held: 1 IDLE cycle, then ack=0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001..., no gaps.
REQ-025 Only req[2] high, wren[2]=0, addr slice 12'h0A5, single cycle: ack=0100 with mem_addr=12'h0A5; next cycle rvalid=0100, rdata=mem_dataout.
REQ-026 Port 0 owns burst, drops req after 2 acks, req[3]=1: one cycle mem_en=0, IDLE cycle, then ack=1000.
REQ-027 Only req[1] held, MAX_BURST=4: ack=0010 every cycle after first IDLE, consecutive bursts with no gap.
REQ-028 READ_LATENCY=3, port 0 issues reads at cycles t, t+1, then srst_n=0 at t+2: no rvalid at t+3/t+4; after release with req=1111, port 0 granted first.
REQ-029 MAX_BURST=1, req=0101 held: ack alternates 0001, 0100 every cycle.
